// File: rtl/pwm_frame_sequencer.sv
// rtl/pwm_frame_sequencer.sv - frame buffer and load sequencer for the multi-stage PWM block
//
// Purpose: buffers duty words from an upstream valid/ready stream. Once a full
// frame of STAGE words is held, it replays the PWM load protocol: a one-cycle
// start strobe carrying word 0, then words 1..STAGE-1 on consecutive cycles.
// After that it waits for the PWM hsync latch indication before the next frame.
//
// Ports:
//   clkfordata_i   only clock, rising edge
//   rst_i          synchronous active-high reset
//   enable_i       permits new frames to start
//   in_valid_i     upstream word valid
//   in_ready_o     buffer can accept a word
//   in_data_i      upstream duty word
//   start_o        PWM start strobe, coincident with word 0
//   data_o         PWM duty data
//   hsync_i        PWM frame-latch indication, asynchronous to clkfordata_i
//   busy_o         high while loading or waiting for the latch
//   frame_count_o  frames acknowledged by hsync, wraps 0xFFFF -> 0
//   timeout_err_o  sticky: hsync not seen within TIMEOUT cycles

module pwm_frame_sequencer #(
  parameter int STAGE      = 8,
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic              clkfordata_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] in_data_i,
  output logic              start_o,
  output logic [DWIDTH-1:0] data_o,
  input  logic              hsync_i,
  output logic              busy_o,
  output logic [15:0]       frame_count_o,
  output logic              timeout_err_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STAGE_C  = CW'(STAGE);
  localparam logic [IW-1:0] LAST_IDX = IW'(STAGE - 1);
  localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push;
  logic              pop;
  logic [DWIDTH-1:0] head;

  // Ready follows the registered count only, so a full buffer stays not-ready
  // even on a cycle where the sequencer pops.
  assign in_ready_o = (count_q < DEPTH_C);
  assign push       = in_valid_i & in_ready_o;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clkfordata_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= in_data_i;
  end

  // ---------------------------------------------------------------------------
  // hsync synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic hs_meta_q, hs_sync_q, hs_prev_q;
  logic hs_rise;

  assign hs_rise = hs_sync_q & ~hs_prev_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              start_q, start_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tcnt_d        = tcnt_q;
    start_d       = 1'b0;
    data_d        = '0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A frame only starts once fully buffered, so LOAD can never underrun.
        if (enable_i && (count_q >= STAGE_C)) begin
          pop     = 1'b1;
          data_d  = head;
          start_d = 1'b1;
          idx_d   = IW'(1);
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        pop    = 1'b1;
        data_d = head;
        idx_d  = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        // A latch arriving on the timeout edge still counts as acknowledged.
        if (hs_rise) begin
          frame_count_d = frame_count_q + 16'd1;
          tcnt_d        = '0;
          state_d       = ST_IDLE;
        end else if (tcnt_q == TLAST) begin
          timeout_err_d = 1'b1;
          tcnt_d        = '0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkfordata_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hs_meta_q     <= 1'b0;
      hs_sync_q     <= 1'b0;
      hs_prev_q     <= 1'b0;
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tcnt_q        <= '0;
      start_q       <= 1'b0;
      data_q        <= '0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      hs_meta_q     <= hsync_i;
      hs_sync_q     <= hs_meta_q;
      hs_prev_q     <= hs_sync_q;
      state_q       <= state_d;
      idx_q         <= idx_d;
      tcnt_q        <= tcnt_d;
      start_q       <= start_d;
      data_q        <= data_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign start_o       = start_q;
  assign data_o        = data_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_count_o = frame_count_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: doc/pwm_frame_sequencer.md
Name: pwm_frame_sequencer

Overview:
Controller that feeds the multi-stage PWM block one frame of duty values at a time. It buffers duty words from an upstream valid/ready stream and, once a full frame of STAGE words is buffered, replays the PWM load protocol. That protocol is a 1-cycle start pulse with word 0, followed by words 1..STAGE-1 on consecutive cycles. The block then waits for the PWM hsync latch indication before loading the next frame, and sits between the duty-value source and the PWM instance in the clkfordata domain.

Parameters:
STAGE, 8, words per frame (number of PWM channels)
DWIDTH, 8, duty word width
FIFO_DEPTH, 16, input buffer depth in words (must be >= STAGE, power of 2)
TIMEOUT, 64, clkfordata cycles to wait for hsync before flagging error

Ports:
clkfordata  in  1  the block's only clock; all logic on its rising edge
rst  in  1  reset, synchronous and active-high
enable  in  1  permits new frames to start
in_valid  in  1  upstream word valid
in_ready  out  1  buffer can accept a word
in_data  in  DWIDTH  upstream duty word
start  out  1  PWM start strobe
data  out  DWIDTH  PWM duty data
hsync  in  1  PWM frame-latch indication, asynchronous to clkfordata
busy  out  1  high in LOAD or WAIT_LATCH
frame_count  out  16  frames acknowledged by hsync, wraps 0xFFFF->0
timeout_err  out  1  sticky: hsync not seen within TIMEOUT

Behaviour:
- Reset (rst=1 at an edge): all state clears.
  - start=0, data=0, busy=0, frame_count=0, timeout_err=0.
  - FIFO emptied (count=0), in_ready=1, FSM=IDLE, synchronizer flops=0.
  - Reset mid-frame abandons the frame; buffered words are discarded.
- FIFO push and in_ready:
  - in_ready = (count < FIFO_DEPTH), registered-count based.
  - Push when in_valid && in_ready.
  - When full, in_ready=0 even if a pop occurs that cycle.
  - Simultaneous push and pop leave count unchanged.
- hsync handling: passes a 2-flop synchronizer, then rising-edge detect, giving hs_rise (3 cycles of latency from the hsync edge).
- FSM states: IDLE, LOAD, WAIT_LATCH.
- IDLE:
  - At an edge with enable=1 and count>=STAGE: pop word0; data<=word0; start<=1; idx<=1; go to LOAD.
  - Otherwise start<=0, data<=0.
  - hs_rise is ignored.
- LOAD:
  - Each edge: pop word idx; data<=word; start<=0; idx++.
  - At the edge popping idx=STAGE-1, go to WAIT_LATCH.
  - Result: start is high exactly 1 cycle, coincident with word0; data words appear on STAGE consecutive cycles.
  - No underrun is possible, since the frame starts only when fully buffered.
  - enable and hs_rise are ignored.
- WAIT_LATCH:
  - start=0; data<=0; tcnt increments each cycle.
  - On hs_rise: frame_count++, tcnt<=0, go to IDLE.
  - Else if tcnt==TIMEOUT-1: timeout_err<=1, tcnt<=0, go to IDLE (frame_count unchanged).
  - If hs_rise and the timeout fall on the same edge, hs_rise wins.
- enable deasserted mid-frame: the frame completes normally, and no new frame starts.
- Back-to-back frames: at the earliest, the next start occurs one cycle after leaving WAIT_LATCH, i.e. the IDLE decision edge.
- busy = (state != IDLE).
- timeout_err is cleared only by rst.

Test Plan:
- Basic frame:
  - Stimulus: push 0x10..0x17, enable=1, pulse hsync after load.
  - Required: start=1 for one cycle with data=0x10; data=0x11..0x17 on the next 7 cycles; then data=0; frame_count=1 three cycles after the hsync edge; busy falls on the same edge.
- Partial frame:
  - Stimulus: push 7 words with enable=1.
  - Required: start stays 0 and busy=0; pushing the 8th word produces start on the following edge.
- Backpressure:
  - Stimulus: enable=0, offer 20 words continuously.
  - Required: exactly 16 accepted; in_ready=0 after the 16th. Then set enable=1: in_ready returns to 1 one cycle after the first pop.
- Timeout:
  - Stimulus: load a frame, never pulse hsync.
  - Required: timeout_err=1 exactly 64 cycles after entering WAIT_LATCH; FSM returns to IDLE; a second buffered frame then loads normally; frame_count stays 0.
- Reset mid-LOAD:
  - Stimulus: assert rst while word3 is on data.
  - Required: next cycle start=0, data=0, busy=0, in_ready=1. A new 8-word frame after reset emits its own word0 first, with no stale words.
- Ignored hsync and wrap:
  - Stimulus: pulse hsync during LOAD.
  - Required: frame_count unchanged. Force frame_count=0xFFFF, complete a frame: frame_count=0x0000.
